// File: rtl/mdu_if.sv
// Handshake and result bundle between EX control and the
// iterative multiply/divide unit.
interface mdu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic             hi_we;
   logic             lo_we;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, abort, hi_we, lo_we,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, abort, hi_we, lo_we,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One shift-add or restoring-subtract step per clock.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input logic clk,
   input logic rst_n,
   mdu_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_n;

   logic             busy, load, step, fix_wr, cancel;
   logic [CW-1:0]    cnt;
   logic             is_div, neg_lo, neg_hi, dz, dz_prev;
   logic [WIDTH-1:0] opnd;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] hi_r, lo_r;
   logic             done_r, div_zero_r;

   logic             sgn, sa, sb;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rsh;
   logic             ge;
   logic [2*WIDTH-1:0] acc_n, prod;
   logic [WIDTH-1:0] rem_n, quo, rmd;
   logic             wr_hi, wr_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (bus.start) state_n = CALC;
         CALC: begin
            if (bus.abort)        state_n = IDLE;
            else if (cnt == LAST) state_n = FIX;
         end
         FIX:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      load   = 1'b0;
      step   = 1'b0;
      fix_wr = 1'b0;
      cancel = 1'b0;
      unique case (state)
         IDLE: load = bus.start;
         CALC: begin
            busy   = 1'b1;
            step   = !bus.abort;
            cancel = bus.abort;
         end
         FIX: begin
            busy   = 1'b1;
            fix_wr = !bus.abort;
            cancel = bus.abort;
         end
         default: ;
      endcase
   end

   // Operand conditioning at launch; op[0]=1 selects unsigned.
   always_comb begin
      sgn   = !bus.op[0];
      sa    = sgn & bus.a[WIDTH-1];
      sb    = sgn & bus.b[WIDTH-1];
      a_mag = sa ? -bus.a : bus.a;
      b_mag = sb ? -bus.b : bus.b;
      wr_hi = (state == IDLE) && !bus.start && bus.hi_we;
      wr_lo = (state == IDLE) && !bus.start && bus.lo_we;
   end

   // Mult keeps the multiplier in acc[W-1:0]; div keeps the dividend there
   // and shifts quotient bits in from the bottom.
   always_comb begin
      sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
      rsh   = {rem, acc[WIDTH-1]};
      ge    = rsh >= {1'b0, opnd};
      rem_n = ge ? (rsh[WIDTH-1:0] - opnd) : rsh[WIDTH-1:0];
      if (is_div) acc_n = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
      else        acc_n = {sum, acc[WIDTH-1:1]};
      prod = neg_lo ? -acc : acc;
      quo  = dz ? '1 : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      rmd  = neg_hi ? -rem : rem;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         is_div     <= 1'b0;
         neg_lo     <= 1'b0;
         neg_hi     <= 1'b0;
         dz         <= 1'b0;
         dz_prev    <= 1'b0;
         opnd       <= '0;
         acc        <= '0;
         rem        <= '0;
         hi_r       <= '0;
         lo_r       <= '0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         done_r <= fix_wr;
         if (load) begin
            cnt        <= '0;
            is_div     <= bus.op[1];
            neg_lo     <= sa ^ sb;
            neg_hi     <= sa;
            dz         <= bus.op[1] && (bus.b == '0);
            opnd       <= bus.op[1] ? b_mag : a_mag;
            acc        <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            rem        <= '0;
            dz_prev    <= div_zero_r;
            div_zero_r <= 1'b0;
         end
         if (wr_hi) hi_r <= bus.a;
         if (wr_lo) lo_r <= bus.a;
         if (step) begin
            acc <= acc_n;
            rem <= rem_n;
            cnt <= cnt + 1'b1;
         end
         if (fix_wr) begin
            hi_r       <= is_div ? rmd : prod[2*WIDTH-1:WIDTH];
            lo_r       <= is_div ? quo : prod[WIDTH-1:0];
            div_zero_r <= dz;
         end
         // A flushed op must leave div_zero as it was before launch.
         if (cancel) div_zero_r <= dz_prev;
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done_r;
   assign bus.div_zero = div_zero_r;
   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit (WIDTH=32).
// Table of ops plus hand sequences for abort/reset/handshake corners.
module tb_mul_div_unit;
   localparam int W = 32;

   logic clk;
   logic rst_n;
   mdu_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vec_t;

   vec_t vt [14];
   int checks = 0;
   int failures = 0;
   logic [W-1:0] exp_hi, exp_lo;
   logic exp_dz;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!bus.done && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic launch(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
      bus.op = o;
      bus.a = x;
      bus.b = y;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic check_res(input string tag, input int n,
                            input logic [W-1:0] h, input logic [W-1:0] l,
                            input logic d);
      chk({tag, ".lat"}, 64'(n), 64'(W + 1));
      chk({tag, ".hi"}, 64'(bus.hi), 64'(h));
      chk({tag, ".lo"}, 64'(bus.lo), 64'(l));
      chk({tag, ".dz"}, 64'(bus.div_zero), 64'(d));
      chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
      exp_hi = h;
      exp_lo = l;
      exp_dz = d;
   endtask

   initial begin
      int n;
      int pulses;
      vt[0]  = '{2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vt[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0};
      vt[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vt[3]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
      vt[4]  = '{2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1};
      vt[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0};
      vt[6]  = '{2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vt[7]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0};
      vt[8]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 1'b0};
      vt[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0};
      vt[10] = '{2'b01, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0};
      vt[11] = '{2'b11, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b0};
      vt[12] = '{2'b00, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 1'b0};
      vt[13] = '{2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.a = '0;
      bus.b = '0;
      bus.abort = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      tick();
      tick();
      chk("rst.busy", 64'(bus.busy), 64'd0);
      chk("rst.done", 64'(bus.done), 64'd0);
      chk("rst.dz", 64'(bus.div_zero), 64'd0);
      chk("rst.hi", 64'(bus.hi), 64'd0);
      chk("rst.lo", 64'(bus.lo), 64'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         launch(vt[i].op, vt[i].a, vt[i].b);
         chk($sformatf("v%0d.busy_after_start", i), 64'(bus.busy), 64'd1);
         wait_done(n);
         check_res($sformatf("v%0d", i), n, vt[i].hi, vt[i].lo, vt[i].dz);
         tick();
         chk($sformatf("v%0d.done_drop", i), 64'(bus.done), 64'd0);
      end

      // Abort mid-CALC, with ignored start/hi_we/lo_we while busy.
      launch(2'b00, 32'd3, 32'd5);
      repeat (4) tick();
      bus.op = 2'b01;
      bus.a = 32'hDEADBEEF;
      bus.b = 32'd9;
      bus.start = 1'b1;
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      chk("ab.busy_mid", 64'(bus.busy), 64'd1);
      chk("ab.hi_mid", 64'(bus.hi), 64'(exp_hi));
      chk("ab.lo_mid", 64'(bus.lo), 64'(exp_lo));
      repeat (5) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("ab.busy", 64'(bus.busy), 64'd0);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) pulses++;
         tick();
      end
      chk("ab.no_done", 64'(pulses), 64'd0);
      chk("ab.busy_end", 64'(bus.busy), 64'd0);
      chk("ab.hi", 64'(bus.hi), 64'(exp_hi));
      chk("ab.lo", 64'(bus.lo), 64'(exp_lo));
      chk("ab.dz", 64'(bus.div_zero), 64'(exp_dz));

      // Abort landing in FIX must block the write.
      launch(2'b11, 32'd100, 32'd7);
      repeat (W) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abfix.done", 64'(bus.done), 64'd0);
      chk("abfix.busy", 64'(bus.busy), 64'd0);
      chk("abfix.hi", 64'(bus.hi), 64'(exp_hi));
      chk("abfix.lo", 64'(bus.lo), 64'(exp_lo));
      tick();
      chk("abfix.done2", 64'(bus.done), 64'd0);

      // Abort in IDLE is a no-op.
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abidle.busy", 64'(bus.busy), 64'd0);
      chk("abidle.lo", 64'(bus.lo), 64'(exp_lo));

      // Next start clears div_zero; start wins over lo_we.
      bus.lo_we = 1'b1;
      launch(2'b11, 32'h55, 32'd5);
      bus.lo_we = 1'b0;
      chk("clr.dz", 64'(bus.div_zero), 64'd0);
      chk("prio.lo", 64'(bus.lo), 64'(exp_lo));
      wait_done(n);
      check_res("prio", n, 32'd0, 32'd17, 1'b0);

      // Back-to-back start in the done cycle.
      launch(2'b01, 32'd6, 32'd7);
      wait_done(n);
      check_res("b2b0", n, 32'd0, 32'd42, 1'b0);
      launch(2'b11, 32'd100, 32'd7);
      chk("b2b.busy", 64'(bus.busy), 64'd1);
      chk("b2b.done", 64'(bus.done), 64'd0);
      wait_done(n);
      check_res("b2b1", n, 32'd2, 32'd14, 1'b0);
      tick();

      // MTLO / MTHI in IDLE.
      bus.a = 32'h1234;
      bus.lo_we = 1'b1;
      tick();
      bus.lo_we = 1'b0;
      chk("mtlo.lo", 64'(bus.lo), 64'h1234);
      chk("mtlo.hi", 64'(bus.hi), 64'd2);
      chk("mtlo.done", 64'(bus.done), 64'd0);
      bus.a = 32'hABCD;
      bus.hi_we = 1'b1;
      tick();
      bus.hi_we = 1'b0;
      chk("mthi.hi", 64'(bus.hi), 64'hABCD);
      chk("mthi.lo", 64'(bus.lo), 64'h1234);

      // Reset asserted mid-op.
      launch(2'b11, 32'd5, 32'd0);
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmid.busy", 64'(bus.busy), 64'd0);
      chk("rmid.hi", 64'(bus.hi), 64'd0);
      chk("rmid.lo", 64'(bus.lo), 64'd0);
      chk("rmid.dz", 64'(bus.div_zero), 64'd0);
      tick();
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) pulses++;
         tick();
      end
      chk("rmid.no_done", 64'(pulses), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
